fab_cfg_streamer: RTL and testbench
===================================

Name: fab_cfg_streamer

Overview:
Synthesizable bitstream loader for the FABulous eFPGA fabric.
- Accepts 32-bit bitstream words over a valid/ready stream and bit-bangs them into the fabric's serial config port (s_clk/s_data). Each bit is sent as a data phase followed by a control-word phase.
- After the last word, waits a programmable settle time, then pulses a user-design reset into the fabric.
- Sits between an on-chip bitstream source (SPI flash reader / Wishbone FIFO) and the fabric's s_clk/s_data pins, replacing bench-driven bit-banging.

Parameters:
- CTRL_WORD, 32'h0000FAB1, control word serialised MSB-first in the second half of each bit slot.
- DIV, 1, phase length in CLK cycles (>=1; 0 is illegal and flagged by an elaboration-time check).
- POST_WAIT, 100, CLK cycles from end of last bit to fab_rst assertion.
- RST_CYCLES, 5, fab_rst high time in CLK cycles (>=1).
- CNT_W, 13, width of words_sent.

Ports:
- CLK, in, 1, system clock; all logic is rising-edge.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, single-cycle pulse that begins a load; honoured in IDLE/DONE only.
- abort, in, 1, cancels any operation; level-sensitive, checked every cycle.
- in_data, in, 32, bitstream word; byte0 is in [31:24] and is sent MSB first.
- in_last, in, 1, marks the final word; qualified by the handshake.
- in_valid, in, 1, word available.
- in_ready, out, 1, word accepted when in_valid && in_ready.
- s_clk, out, 1, serial config clock to the fabric (registered).
- s_data, out, 1, serial config data to the fabric (registered).
- fab_rst, out, 1, user-design reset to the fabric (registered).
- busy, out, 1, high in LOAD/SHIFT/POST/URST.
- done, out, 1, high in DONE.
- words_sent, out, CNT_W, completed words since last start; saturates at all-ones.

Behaviour:
- Reset: state=IDLE; s_clk=0, s_data=0, fab_rst=0, busy=0, done=0, words_sent=0, in_ready=0.
- States: IDLE, LOAD, SHIFT, POST, URST, DONE.
- IDLE/DONE + start -> LOAD; words_sent cleared; done drops.
- LOAD: in_ready = (state==LOAD) && !abort, combinational. On handshake: latch word and last flag, bit index j=0, go to SHIFT. s_clk/s_data hold their previous values during LOAD.
- SHIFT, per bit j (0..31, bit = word[31-j]); four phases, outputs registered and valid from the first cycle of each phase:
  - P0, DIV cycles: s_clk=0, s_data=bit.
  - P1, DIV cycles: s_clk=1, s_data=bit. Fabric samples data on this rising edge.
  - P2, DIV cycles: s_clk=1, s_data=CTRL_WORD[31-j].
  - P3, 2*DIV cycles: s_clk=0, s_data=CTRL_WORD[31-j].
- Bit slot is 5*DIV cycles; a word is 160*DIV cycles. First P0 cycle is the cycle after the handshake.
- End of bit 31's P3: words_sent += 1 (saturating). If last -> POST, else -> LOAD. Back-to-back word spacing with in_valid held: 160*DIV+1 cycles.
- POST: s_clk=0, s_data=0. Count POST_WAIT cycles, then -> URST.
- URST: fab_rst=1 for exactly RST_CYCLES cycles, then -> DONE with fab_rst=0.
- DONE: done=1 until start or reset.
- abort in any non-IDLE state: next cycle state=IDLE; s_clk=0, s_data=0, fab_rst=0, busy=0, done=0; words_sent holds. abort has priority over handshake, start and phase advance.
- start while busy: ignored. start && abort together: abort wins.
- reset has priority over everything, including mid-word and mid-URST. No partial fab_rst pulse survives reset.
- in_data/in_last are ignored without a handshake. The latched word is immune to in_data changes during SHIFT.

Decomposition:
- fab_cfg_pkg holds:
  - state enum (IDLE..DONE);
  - phase enum (P0..P3);
  - localparam default CTRL_WORD=32'h0000FAB1;
  - function returning the phase length given phase and DIV.
- Sub-module fab_cfg_bit_phy: given a 32-bit word, CTRL_WORD and a go pulse, generates the 4-phase s_clk/s_data waveform and a word_done pulse.
- Top FSM handles the handshake, POST/URST and counters.

Test Plan:
- Bench model: capture s_data on every s_clk rise as data and on every fall as ctrl; compare 32-bit accumulations.
- DIV=1, one word 0xA5C30F01 with last=1 -> 32 s_clk rises; data capture=0xA5C30F01, ctrl capture=0x0000FAB1; SHIFT lasts 160 cycles; words_sent=1.
- Three words (0x11111111, 0x22222222, 0x33333333, last on third), in_valid held -> in_ready high exactly 1 cycle per word, 161-cycle spacing; captures match in order; words_sent=3.
- Post sequence with defaults -> fab_rst rises exactly 100 cycles after last P3 ends, stays high 5 cycles; done=1 the following cycle; busy=0.
- abort during bit 10 of word 2 -> next cycle s_clk=0, s_data=0, in_ready=0, busy=0, words_sent=1. New start resends a full word from bit 31; the bench sees 32 clean rises.
- DIV=3 -> s_clk high 6 cycles, low 9 cycles, bit period 15, word 480 cycles; captures still 0xA5C30F01/0x0000FAB1.
- reset asserted 3 cycles into URST -> fab_rst=0 next cycle, state IDLE, all outputs zero; start without reset -> LOAD.

Source files
------------

// File: rtl/fab_cfg_pkg.sv
// Shared types and helpers for the FABulous serial configuration streamer.
package fab_cfg_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StPost,
        StUrst,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        PhData,
        PhClkHi,
        PhCtrlHi,
        PhCtrlLo
    } phase_e;

    localparam logic [31:0] DefaultCtrlWord = 32'h0000FAB1;

    // The trailing low phase is doubled so a bit slot spans 5*DIV cycles.
    function automatic int unsigned phase_len(phase_e ph, int unsigned div);
        return (ph == PhCtrlLo) ? 2 * div : div;
    endfunction

endpackage

// File: rtl/fab_cfg_bit_phy.sv
// Serialises one 32-bit word as 4-phase s_clk/s_data bit slots, data then control word.
module fab_cfg_bit_phy
    import fab_cfg_pkg::*;
#(
    parameter logic [31:0] CTRL_WORD = DefaultCtrlWord,
    parameter int unsigned DIV       = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        go,
    input  logic [31:0] word,
    output logic        s_clk,
    output logic        s_data,
    output logic        word_done
);

    localparam int unsigned CntW = $clog2(2 * DIV);

    logic            active_q, active_d;
    logic [31:0]     word_q, word_d;
    logic [4:0]      bit_q, bit_d, bit_nxt;
    phase_e          phase_q, phase_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            s_clk_q, s_clk_d;
    logic            s_data_q, s_data_d;
    logic            phase_end;

    assign bit_nxt   = bit_q + 5'd1;
    assign phase_end = (cnt_q == CntW'(phase_len(phase_q, DIV) - 1));
    assign word_done = active_q && phase_end && (phase_q == PhCtrlLo) && (bit_q == 5'd31);
    assign s_clk     = s_clk_q;
    assign s_data    = s_data_q;

    // Outputs are computed one edge ahead so they are valid on the first cycle of a phase.
    always_comb begin
        active_d = active_q;
        word_d   = word_q;
        bit_d    = bit_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        s_clk_d  = s_clk_q;
        s_data_d = s_data_q;
        if (clear) begin
            active_d = 1'b0;
            s_clk_d  = 1'b0;
            s_data_d = 1'b0;
        end else if (go) begin
            active_d = 1'b1;
            word_d   = word;
            bit_d    = '0;
            phase_d  = PhData;
            cnt_d    = '0;
            s_clk_d  = 1'b0;
            s_data_d = word[31];
        end else if (active_q) begin
            if (!phase_end) begin
                cnt_d = cnt_q + CntW'(1);
            end else begin
                cnt_d = '0;
                unique case (phase_q)
                    PhData: begin
                        phase_d = PhClkHi;
                        s_clk_d = 1'b1;
                    end
                    PhClkHi: begin
                        phase_d  = PhCtrlHi;
                        s_data_d = CTRL_WORD[~bit_q];
                    end
                    PhCtrlHi: begin
                        phase_d = PhCtrlLo;
                        s_clk_d = 1'b0;
                    end
                    PhCtrlLo: begin
                        if (bit_q == 5'd31) begin
                            active_d = 1'b0;
                        end else begin
                            bit_d    = bit_nxt;
                            phase_d  = PhData;
                            s_data_d = word_q[~bit_nxt];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            word_q   <= '0;
            bit_q    <= '0;
            phase_q  <= PhData;
            cnt_q    <= '0;
            s_clk_q  <= 1'b0;
            s_data_q <= 1'b0;
        end else begin
            active_q <= active_d;
            word_q   <= word_d;
            bit_q    <= bit_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            s_clk_q  <= s_clk_d;
            s_data_q <= s_data_d;
        end
    end

endmodule

// File: rtl/fab_cfg_streamer.sv
// Streams bitstream words into the FABulous config port, then settles and pulses fab_rst.
module fab_cfg_streamer
    import fab_cfg_pkg::*;
#(
    parameter logic [31:0] CTRL_WORD  = DefaultCtrlWord,
    parameter int unsigned DIV        = 1,
    parameter int unsigned POST_WAIT  = 100,
    parameter int unsigned RST_CYCLES = 5,
    parameter int unsigned CNT_W      = 13
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             s_clk,
    output logic             s_data,
    output logic             fab_rst,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] words_sent
);

    localparam int unsigned WaitMax = (POST_WAIT > RST_CYCLES) ? POST_WAIT : RST_CYCLES;
    localparam int unsigned WaitW   = $clog2(WaitMax + 1);

    if (DIV == 0) begin : g_div_check
        $error("fab_cfg_streamer: DIV must be at least 1");
    end
    if (RST_CYCLES == 0) begin : g_rst_check
        $error("fab_cfg_streamer: RST_CYCLES must be at least 1");
    end

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]   words_q, words_d;
    logic               last_q, last_d;
    logic               fab_rst_q;
    logic               handshake, word_done, phy_clear;

    assign in_ready   = (state_q == StLoad) && !abort;
    assign handshake  = in_valid && in_ready;
    assign busy       = state_q inside {StLoad, StShift, StPost, StUrst};
    assign done       = (state_q == StDone);
    assign words_sent = words_q;
    assign fab_rst    = fab_rst_q;
    // Park the serial pins low on abort and once the final word has gone out.
    assign phy_clear  = abort || ((state_q == StShift) && word_done && last_q);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        words_d = words_q;
        last_d  = last_q;
        if (abort) begin
            state_d = StIdle;
            wait_d  = '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_d = StLoad;
                        words_d = '0;
                    end
                end
                StLoad: begin
                    if (handshake) begin
                        last_d  = in_last;
                        state_d = StShift;
                    end
                end
                StShift: begin
                    if (word_done) begin
                        if (words_q != '1) words_d = words_q + CNT_W'(1);
                        wait_d = '0;
                        if (!last_q)              state_d = StLoad;
                        else if (POST_WAIT == 0)  state_d = StUrst;
                        else                      state_d = StPost;
                    end
                end
                StPost: begin
                    if (wait_q == WaitW'(POST_WAIT - 1)) begin
                        wait_d  = '0;
                        state_d = StUrst;
                    end else begin
                        wait_d = wait_q + WaitW'(1);
                    end
                end
                StUrst: begin
                    if (wait_q == WaitW'(RST_CYCLES - 1)) begin
                        wait_d  = '0;
                        state_d = StDone;
                    end else begin
                        wait_d = wait_q + WaitW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= StIdle;
            wait_q    <= '0;
            words_q   <= '0;
            last_q    <= 1'b0;
            fab_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            words_q   <= words_d;
            last_q    <= last_d;
            fab_rst_q <= (state_d == StUrst);
        end
    end

    fab_cfg_bit_phy #(
        .CTRL_WORD(CTRL_WORD),
        .DIV      (DIV)
    ) u_phy (
        .clk      (CLK),
        .reset    (reset),
        .clear    (phy_clear),
        .go       (handshake),
        .word     (in_data),
        .s_clk    (s_clk),
        .s_data   (s_data),
        .word_done(word_done)
    );

endmodule

// File: tb/tb_fab_cfg_streamer.sv
// Scoreboard bench: two streamer instances (DIV=1 and DIV=3) exercised one after the other.
module tb_fab_cfg_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v[2], start_v[2], abort_v[2], in_last_v[2], in_valid_v[2];
    logic [31:0] in_data_v[2];
    logic        in_ready_v[2], s_clk_v[2], s_data_v[2], fab_rst_v[2], busy_v[2], done_v[2];
    logic [12:0] ws_v[2];

    int sel = 0;
    int cyc = 0;
    int rdy_cnt = 0;
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    for (genvar g = 0; g < 2; g++) begin : g_lane
        fab_cfg_streamer #(
            .CTRL_WORD (32'h0000FAB1),
            .DIV       ((g == 0) ? 1 : 3),
            .POST_WAIT ((g == 0) ? 100 : 20),
            .RST_CYCLES((g == 0) ? 5 : 4),
            .CNT_W     (13)
        ) u_dut (
            .CLK       (clk),
            .reset     (rst_v[g]),
            .start     (start_v[g]),
            .abort     (abort_v[g]),
            .in_data   (in_data_v[g]),
            .in_last   (in_last_v[g]),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_v[g]),
            .s_clk     (s_clk_v[g]),
            .s_data    (s_data_v[g]),
            .fab_rst   (fab_rst_v[g]),
            .busy      (busy_v[g]),
            .done      (done_v[g]),
            .words_sent(ws_v[g])
        );
    end

    function automatic int div_of(int l); return (l == 0) ? 1 : 3; endfunction
    function automatic int pw_of(int l);  return (l == 0) ? 100 : 20; endfunction
    function automatic int rc_of(int l);  return (l == 0) ? 5 : 4; endfunction

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (lane %0d, cycle %0d): got 0x%0h, expected 0x%0h",
                     name, sel, cyc, act, exp);
        end
    endfunction

    function automatic logic [18:0] snap(int l);
        return {s_clk_v[l], s_data_v[l], in_ready_v[l], busy_v[l], done_v[l], fab_rst_v[l],
                ws_v[l]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (in_ready_v[sel]) rdy_cnt <= rdy_cnt + 1;

    // Reference capture: data on every s_clk rise, control on every fall, per 32-bit word.
    initial begin : monitor
        logic        prev;
        logic [31:0] dacc, cacc, w;
        int          rises, falls, run;
        bit          hi_bad, lo_bad;
        prev = 1'b0; dacc = '0; cacc = '0;
        rises = 0; falls = 0; run = 0; hi_bad = 0; lo_bad = 0;
        forever begin
            @(negedge clk);
            if (rst_v[sel] !== 1'b0 || busy_v[sel] !== 1'b1) begin
                rises = 0; falls = 0; run = 0; hi_bad = 0; lo_bad = 0;
                prev = s_clk_v[sel];
            end else if (s_clk_v[sel] !== prev) begin
                if (s_clk_v[sel]) begin
                    if (rises > 0 && run != 3 * div_of(sel)) lo_bad = 1;
                    dacc = {dacc[30:0], s_data_v[sel]};
                    rises++;
                end else begin
                    if (run != 2 * div_of(sel)) hi_bad = 1;
                    cacc = {cacc[30:0], s_data_v[sel]};
                    falls++;
                    if (falls == 32) begin
                        chk("scoreboard has word", exp_q.size() != 0, 1);
                        if (exp_q.size() != 0) begin
                            w = exp_q.pop_front();
                            chk("data capture", dacc, w);
                            chk("ctrl capture", cacc, 32'h0000FAB1);
                            chk("rises per word", rises, 32);
                            chk("s_clk high time", hi_bad, 0);
                            chk("s_clk low time", lo_bad, 0);
                        end
                        rises = 0; falls = 0; hi_bad = 0; lo_bad = 0;
                    end
                end
                prev = s_clk_v[sel];
                run = 1;
            end else begin
                run++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_v[sel] = 1'b1;
        tick();
        start_v[sel] = 1'b0;
    endtask

    // Presents a word (after an optional idle gap), returns the cycle the handshake happened.
    task automatic send_word(input logic [31:0] w, input logic lst, input int gap,
                             output int hs);
        hs = -1;
        if (gap > 0) begin
            in_valid_v[sel] = 1'b0;
            in_last_v[sel]  = 1'b1;
            in_data_v[sel]  = $urandom();
            repeat (gap) tick();
        end
        in_valid_v[sel] = 1'b1;
        in_data_v[sel]  = w;
        in_last_v[sel]  = lst;
        for (int k = 0; k < 170 * div_of(sel) + 20 && hs < 0; k++) begin
            @(negedge clk);
            if (in_ready_v[sel]) hs = cyc;
        end
        if (hs < 0) chk("handshake timeout", 0, 1);
        else exp_q.push_back(w);
        tick();
        in_data_v[sel] = $urandom();
    endtask

    // Expected post-load timeline measured from the final word's handshake cycle.
    task automatic post_check(input int h, input int nw);
        int d, rise, width, donec;
        logic bsy;
        logic [12:0] ws;
        d = div_of(sel); rise = -1; width = 0; donec = -1; bsy = 1'bx; ws = 'x;
        pulse_start();
        for (int k = 0; k < 160 * d + pw_of(sel) + rc_of(sel) + 20 && donec < 0; k++) begin
            @(negedge clk);
            if (fab_rst_v[sel]) begin
                if (rise < 0) rise = cyc;
                width++;
            end
            if (done_v[sel]) begin
                donec = cyc;
                bsy   = busy_v[sel];
                ws    = ws_v[sel];
            end
        end
        chk("fab_rst rise cycle", rise, h + 160 * d + pw_of(sel) + 1);
        chk("fab_rst width", width, rc_of(sel));
        chk("done cycle", donec, h + 160 * d + pw_of(sel) + rc_of(sel) + 1);
        chk("busy at done", bsy, 0);
        chk("words_sent at done", ws, nw);
        tick();
    endtask

    task automatic run_lane();
        int d, h, h1, h2, h3, r0, x, n, gap, fr;
        d = div_of(sel);

        rst_v[sel] = 1'b1;
        repeat (3) tick();
        rst_v[sel] = 1'b0;
        @(negedge clk);
        chk("reset state", snap(sel), 19'd0);
        tick();

        pulse_start();
        send_word(32'hA5C30F01, 1'b1, 0, h);
        in_valid_v[sel] = 1'b0;
        post_check(h, 1);

        pulse_start();
        r0 = rdy_cnt;
        send_word(32'h11111111, 1'b0, 0, h1);
        send_word(32'h22222222, 1'b0, 0, h2);
        send_word(32'h33333333, 1'b1, 0, h3);
        in_valid_v[sel] = 1'b0;
        post_check(h3, 3);
        chk("word spacing 1-2", h2 - h1, 160 * d + 1);
        chk("word spacing 2-3", h3 - h2, 160 * d + 1);
        chk("in_ready cycles", rdy_cnt - r0, 3);

        pulse_start();
        send_word($urandom(), 1'b0, 0, h1);
        send_word($urandom(), 1'b0, 0, h2);
        in_valid_v[sel] = 1'b0;
        x = h2 + 1 + 50 * d + d;
        while (cyc < x) tick();
        abort_v[sel] = 1'b1;
        tick();
        abort_v[sel] = 1'b0;
        @(negedge clk);
        chk("abort state", snap(sel), {6'b0, 13'd1});
        exp_q.delete();
        tick();
        pulse_start();
        send_word(32'hCAFEF00D, 1'b1, 0, h);
        in_valid_v[sel] = 1'b0;
        post_check(h, 1);

        repeat (2) begin
            pulse_start();
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) begin
                gap = (i > 0 && $urandom_range(0, 1) == 1) ? 160 * d + $urandom_range(0, 5) : 0;
                send_word($urandom(), (i == n - 1), gap, h);
            end
            in_valid_v[sel] = 1'b0;
            post_check(h, n);
        end

        pulse_start();
        send_word($urandom(), 1'b1, 0, h);
        in_valid_v[sel] = 1'b0;
        fr = 0;
        for (int k = 0; k < 170 * d + 150 && fr < 3; k++) begin
            @(negedge clk);
            if (fab_rst_v[sel]) fr++;
        end
        chk("URST reached", fr, 3);
        tick();
        rst_v[sel] = 1'b1;
        tick();
        rst_v[sel] = 1'b0;
        @(negedge clk);
        chk("reset during URST", snap(sel), 19'd0);
        tick();
        pulse_start();
        @(negedge clk);
        chk("start after reset", {busy_v[sel], in_ready_v[sel], done_v[sel]}, 3'b110);
        tick();
        abort_v[sel] = 1'b1;
        @(negedge clk);
        chk("abort gates in_ready", in_ready_v[sel], 0);
        tick();
        abort_v[sel] = 1'b0;
        @(negedge clk);
        chk("abort returns idle", {busy_v[sel], done_v[sel], s_clk_v[sel]}, 3'b000);
        tick();
    endtask

    initial begin
        for (int l = 0; l < 2; l++) begin
            rst_v[l]      = 1'b1;
            start_v[l]    = 1'b0;
            abort_v[l]    = 1'b0;
            in_valid_v[l] = 1'b0;
            in_last_v[l]  = 1'b0;
            in_data_v[l]  = '0;
        end
        repeat (3) tick();
        for (int l = 0; l < 2; l++) begin
            sel = l;
            run_lane();
        end
        chk("scoreboard drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
